// File: rtl/c4_input_sequencer.sv
// c4_input_sequencer
//   Command front end for the Connect4 game core. Decodes PS/2 set-2
//   scancodes into cursor moves and DROP / NEW_GAME requests, merges them
//   with the drop pushbutton, and queues the resulting commands for the
//   game FSM.
//
//   Parameters
//     NUM_COLS  board columns (cursor range 0..NUM_COLS-1), at most 8
//     QDEPTH    command queue depth, power of two, at least 2
//
//   Ports
//     CLOCK_50     system clock, all logic on the rising edge
//     resetn       synchronous active-low reset
//     ps2_byte     scancode byte, qualified by ps2_byte_en (one-cycle strobe)
//     key_drop_n   raw active-low drop pushbutton (synchronized here)
//     sw_col       column used for pushbutton drops
//     cmd_ready    game core accepts the head command
//     cmd_valid    head command presented (queue non-empty)
//     cmd_op       01 DROP, 10 NEW_GAME, 00 when idle
//     cmd_col      DROP column, 0 for NEW_GAME or when idle
//     cursor_col   keyboard cursor column
//     overflow     sticky: some request was discarded (cleared by reset)
//     queue_count  entries held, 0..QDEPTH
//
//   Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both 1. While cmd_valid=1 and cmd_ready=0 the head
//   (cmd_op/cmd_col) is held stable; cmd_valid never drops without a transfer
//   except on reset.
//
//   Optional feature: define C4_TYPEMATIC_FILTER_EN to ignore keyboard
//   auto-repeat (a make code acts only once until its break code arrives).

module c4_input_sequencer #(
  parameter int NUM_COLS = 7,
  parameter int QDEPTH   = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_en,
  input  logic       key_drop_n,
  input  logic [2:0] sw_col,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [2:0] cmd_col,
  output logic [2:0] cursor_col,
  output logic       overflow,
  output logic [2:0] queue_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
  localparam logic [1:0] OP_DROP = 2'b01;
  localparam logic [1:0] OP_NEW  = 2'b10;

  // bit positions of the per-byte action mask
  localparam int A_LEFT  = 0;
  localparam int A_RIGHT = 1;
  localparam int A_DROP  = 2;
  localparam int A_NEW   = 3;
  localparam int A_DIGIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } dec_state_e;

  function automatic logic digit_hit(input logic [7:0] b);
    digit_hit = (b == 8'h16) || (b == 8'h1E) || (b == 8'h26) || (b == 8'h25) ||
                (b == 8'h2E) || (b == 8'h36) || (b == 8'h3D);
  endfunction

  function automatic logic [2:0] digit_idx(input logic [7:0] b);
    case (b)
      8'h16:   digit_idx = 3'd0;
      8'h1E:   digit_idx = 3'd1;
      8'h26:   digit_idx = 3'd2;
      8'h25:   digit_idx = 3'd3;
      8'h2E:   digit_idx = 3'd4;
      8'h36:   digit_idx = 3'd5;
      8'h3D:   digit_idx = 3'd6;
      default: digit_idx = 3'd0;
    endcase
  endfunction

  // Map a byte (extended or not) to the action it names; digits beyond the
  // board width map to nothing.
  function automatic logic [4:0] classify(input logic [7:0] b, input logic ext);
    classify = '0;
    if (ext) begin
      classify[A_LEFT]  = (b == 8'h6B);
      classify[A_RIGHT] = (b == 8'h74);
    end else begin
      classify[A_DROP]  = (b == 8'h29) || (b == 8'h5A);
      classify[A_NEW]   = (b == 8'h2D);
      classify[A_DIGIT] = digit_hit(b) && (int'(digit_idx(b)) < NUM_COLS);
    end
  endfunction

  dec_state_e    state_q, state_d;
  logic [2:0]    cursor_q, cursor_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    op_mem_q  [QDEPTH];
  logic [1:0]    op_mem_d  [QDEPTH];
  logic [2:0]    col_mem_q [QDEPTH];
  logic [2:0]    col_mem_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, bt_slot;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          make_en, ext_byte;
  logic [4:0]    make_act, act;
  logic          kb_req, kb_acc, bt_req, bt_acc, btn_fall, btn_bad, deq, lost;
  logic [1:0]    kb_op, n_wr;
  logic [2:0]    kb_col;
  int            free_slots;

`ifdef C4_TYPEMATIC_FILTER_EN
  logic          rel_en;
  logic [4:0]    rel_act;
  logic [4:0]    held_q, held_d;
`endif

  // ---------------- scancode decoder ----------------
  always_comb begin
    state_d  = state_q;
    make_en  = 1'b0;
    ext_byte = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
`ifdef C4_TYPEMATIC_FILTER_EN
    rel_en   = 1'b0;
`endif
    if (ps2_byte_en) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_byte == 8'hE0)      state_d = ST_EXT;
          else if (ps2_byte == 8'hF0) state_d = ST_BRK;
          else                        make_en = 1'b1;
        end
        ST_EXT: begin
          if (ps2_byte == 8'hF0) state_d = ST_EXTBRK;
          else begin
            make_en = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          // byte after F0 names the released key
`ifdef C4_TYPEMATIC_FILTER_EN
          rel_en  = 1'b1;
`endif
          state_d = ST_IDLE;
        end
      endcase
    end
    make_act = make_en ? classify(ps2_byte, ext_byte) : 5'b0;
  end

`ifdef C4_TYPEMATIC_FILTER_EN
  // A make whose action is still held is auto-repeat and is dropped.
  always_comb begin
    rel_act = rel_en ? classify(ps2_byte, ext_byte) : 5'b0;
    act     = make_act & ~held_q;
    held_d  = (held_q | act) & ~rel_act;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) held_q <= '0;
    else         held_q <= held_d;
  end
`else
  always_comb act = make_act;
`endif

  // Cursor update and keyboard request; DROP takes the pre-update cursor.
  always_comb begin
    cursor_d = cursor_q;
    if (act[A_LEFT])       cursor_d = (cursor_q == 3'd0) ? LAST_COL : cursor_q - 3'd1;
    else if (act[A_RIGHT]) cursor_d = (cursor_q == LAST_COL) ? 3'd0 : cursor_q + 3'd1;
    else if (act[A_DIGIT]) cursor_d = digit_idx(ps2_byte);
    kb_req = act[A_DROP] | act[A_NEW];
    kb_op  = act[A_DROP] ? OP_DROP : OP_NEW;
    kb_col = act[A_DROP] ? cursor_q : 3'd0;
  end

  // ---------------- pushbutton ----------------
  always_comb begin
    btn_fall = prev_q & ~sync2_q;
    btn_bad  = btn_fall && (int'(sw_col) >= NUM_COLS);
    bt_req   = btn_fall && !btn_bad;
  end

  // ---------------- command queue ----------------
  // Keyboard entry is written ahead of the button entry. When full, a
  // same-cycle dequeue frees the head slot, which equals the write slot.
  always_comb begin
    op_mem_d   = op_mem_q;
    col_mem_d  = col_mem_q;
    deq        = cmd_valid & cmd_ready;
    free_slots = QDEPTH - int'(count_q) + (deq ? 1 : 0);
    kb_acc     = kb_req && (free_slots >= 1);
    bt_acc     = bt_req && (free_slots >= (kb_acc ? 2 : 1));
    lost       = btn_bad | (kb_req & ~kb_acc) | (bt_req & ~bt_acc);
    bt_slot    = kb_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    if (kb_acc) begin
      op_mem_d[wr_ptr_q]  = kb_op;
      col_mem_d[wr_ptr_q] = kb_col;
    end
    if (bt_acc) begin
      op_mem_d[bt_slot]  = OP_DROP;
      col_mem_d[bt_slot] = sw_col;
    end
    n_wr       = {1'b0, kb_acc} + {1'b0, bt_acc};
    wr_ptr_d   = wr_ptr_q + PW'(n_wr);
    rd_ptr_d   = rd_ptr_q + PW'(deq);
    count_d    = count_q + CW'(n_wr) - CW'(deq);
    overflow_d = overflow_q | lost;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cursor_q   <= 3'd0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        op_mem_q[i]  <= 2'b00;
        col_mem_q[i] <= 3'd0;
      end
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      sync1_q    <= key_drop_n;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      op_mem_q   <= op_mem_d;
      col_mem_q  <= col_mem_d;
    end
  end

  assign cmd_valid   = (count_q != '0);
  assign cmd_op      = cmd_valid ? op_mem_q[rd_ptr_q] : 2'b00;
  assign cmd_col     = cmd_valid ? col_mem_q[rd_ptr_q] : 3'd0;
  assign cursor_col  = cursor_q;
  assign overflow    = overflow_q;
  assign queue_count = 3'(count_q);

endmodule

// File: tb/tb_c4_input_sequencer.sv
// Testbench for c4_input_sequencer: directed scenarios followed by random
// scancode / button / ready traffic, all compared every cycle against a
// behavioural model (prefix flags, SV queue of {op,col}, raw button history).

module tb_c4_input_sequencer;

  localparam int NC = 7;
  localparam int QD = 4;
  localparam logic [7:0] DIGIT_CODES [7] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

  // ---------------- clock / reset / DUT ----------------
  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic       key_drop_n;
  logic [2:0] sw_col;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_col;
  logic [2:0] cursor_col;
  logic       overflow;
  logic [2:0] queue_count;

  always #5 CLOCK_50 = ~CLOCK_50;

  c4_input_sequencer #(.NUM_COLS(NC), .QDEPTH(QD)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .ps2_byte    (ps2_byte),
    .ps2_byte_en (ps2_byte_en),
    .key_drop_n  (key_drop_n),
    .sw_col      (sw_col),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_col     (cmd_col),
    .cursor_col  (cursor_col),
    .overflow    (overflow),
    .queue_count (queue_count)
  );

  logic [12:0] dut_status;
  assign dut_status = {cmd_valid, cmd_op, cmd_col, cursor_col, overflow, queue_count};

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0] exp_q[$];   // {op, col}, head at index 0
  int         m_cursor;
  bit         m_ovf;
  bit         m_ext;      // E0 seen, waiting for the rest of the code
  bit         m_brk;      // F0 seen, next byte is a release
  bit         m_hist[$];  // raw key_drop_n sampled at the last three edges
`ifdef C4_TYPEMATIC_FILTER_EN
  bit [5:0]   m_held;
`endif

  function automatic int digit_index(input logic [7:0] b);
    for (int i = 0; i < 7; i++) if (DIGIT_CODES[i] == b) return i;
    return -1;
  endfunction

  // 0 none, 1 left, 2 right, 3 drop, 4 new game, 5 digit
  function automatic int act_of(input logic [7:0] b, input bit ext);
    int d;
    if (ext) begin
      if (b == 8'h6B) return 1;
      if (b == 8'h74) return 2;
      return 0;
    end
    if (b == 8'h29 || b == 8'h5A) return 3;
    if (b == 8'h2D) return 4;
    d = digit_index(b);
    if (d >= 0 && d < NC) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cursor = 0;
    m_ovf    = 0;
    m_ext    = 0;
    m_brk    = 0;
    m_hist   = '{1'b1, 1'b1, 1'b1};
`ifdef C4_TYPEMATIC_FILTER_EN
    m_held   = '0;
`endif
  endtask

  task automatic model_make(input logic [7:0] b, input bit ext, output bit kb_v, output logic [4:0] kb);
    int a;
    a    = act_of(b, ext);
    kb_v = 0;
    kb   = '0;
    if (a == 0) return;
`ifdef C4_TYPEMATIC_FILTER_EN
    if (m_held[a]) return;
    m_held[a] = 1'b1;
`endif
    case (a)
      1: m_cursor = (m_cursor + NC - 1) % NC;
      2: m_cursor = (m_cursor + 1) % NC;
      3: begin kb_v = 1; kb = {2'b01, 3'(m_cursor)}; end
      4: begin kb_v = 1; kb = {2'b10, 3'b000}; end
      default: m_cursor = digit_index(b);
    endcase
  endtask

  // Advance the model across one rising edge using the inputs driven for it.
  task automatic model_step();
    logic [4:0] kb;
    bit         kb_v;
    bit         fall;
    if (!resetn) begin
      model_reset();
      return;
    end
    kb_v = 0;
    kb   = '0;
    if (ps2_byte_en) begin
      if (m_brk) begin
`ifdef C4_TYPEMATIC_FILTER_EN
        if (act_of(ps2_byte, m_ext) != 0) m_held[act_of(ps2_byte, m_ext)] = 1'b0;
`endif
        m_brk = 0;
        m_ext = 0;
      end else if (ps2_byte == 8'hF0) begin
        m_brk = 1;
      end else if (ps2_byte == 8'hE0 && !m_ext) begin
        m_ext = 1;
      end else begin
        model_make(ps2_byte, m_ext, kb_v, kb);
        m_ext = 0;
      end
    end
    // button request is a 1->0 of the value that went in two edges earlier
    fall = (m_hist[0] == 1'b1) && (m_hist[1] == 1'b0);
    m_hist.push_back(key_drop_n);
    void'(m_hist.pop_front());

    if (exp_q.size() > 0 && cmd_ready) void'(exp_q.pop_front());
    if (kb_v) begin
      if (exp_q.size() < QD) exp_q.push_back(kb);
      else m_ovf = 1;
    end
    if (fall) begin
      if (int'(sw_col) >= NC)  m_ovf = 1;
      else if (exp_q.size() < QD) exp_q.push_back({2'b01, sw_col});
      else m_ovf = 1;
    end
  endtask

  function automatic logic [12:0] exp_status();
    bit v;
    v = exp_q.size() > 0;
    return {v, (v ? exp_q[0] : 5'b0), 3'(m_cursor), m_ovf, 3'(exp_q.size())};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic [7:0] b);
    ps2_byte_en = en;
    ps2_byte    = b;
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    check_eq("status", 32'(dut_status), 32'(exp_status()));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    resetn = 1'b1;
  endtask

  task automatic tap(input logic [7:0] b);  // make then break of one key
    step(1'b1, b);
    step(1'b1, 8'hF0);
    step(1'b1, b);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pool [16];
  logic [4:0] heads [4];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hF0, 8'h6B, 8'h74, 8'h16, 8'h1E, 8'h26,
             8'h25, 8'h2E, 8'h36, 8'h3D, 8'h29, 8'h5A, 8'h2D, 8'h12};
    resetn = 1'b0; ps2_byte = 8'h00; ps2_byte_en = 1'b0;
    key_drop_n = 1'b1; sw_col = 3'd0; cmd_ready = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    do_reset();
    check_eq("rst_valid",  32'(cmd_valid),   0);
    check_eq("rst_op",     32'(cmd_op),      0);
    check_eq("rst_cursor", 32'(cursor_col),  0);
    check_eq("rst_ovf",    32'(overflow),    0);
    check_eq("rst_count",  32'(queue_count), 0);

    // space make -> DROP col 0 visible one cycle after the strobe
    step(1'b1, 8'h29);
    check_eq("t1_valid", 32'(cmd_valid), 1);
    check_eq("t1_head",  32'({cmd_op, cmd_col}), 32'({2'b01, 3'd0}));
    step(1'b1, 8'hF0);
    step(1'b1, 8'h29);
    check_eq("t1_count", 32'(queue_count), 1);
    cmd_ready = 1'b1;
    step(1'b0, 8'h00);
    check_eq("t1_drain_count", 32'(queue_count), 0);
    check_eq("t1_drain_op",    32'(cmd_op),      0);

    // cursor wrap and digits
    step(1'b1, 8'hE0); step(1'b1, 8'h6B);
    check_eq("t2_left_wrap", 32'(cursor_col), 6);
    step(1'b1, 8'hE0); step(1'b1, 8'h74);
    step(1'b1, 8'hE0); step(1'b1, 8'h74);
    check_eq("t2_right_wrap", 32'(cursor_col), 1);
    step(1'b1, 8'h3D);
    check_eq("t2_digit7", 32'(cursor_col), 6);
    step(1'b1, 8'h16);
    check_eq("t2_digit1", 32'(cursor_col), 0);

    // five drops into a stalled queue
    cmd_ready = 1'b0;
    repeat (5) tap(8'h29);
    check_eq("t3_count", 32'(queue_count), 4);
    check_eq("t3_ovf",   32'(overflow),    1);
    check_eq("t3_head",  32'({cmd_op, cmd_col}), 32'({2'b01, 3'd0}));

    // keyboard and button in the same cycle with one free slot
    do_reset();
    repeat (3) tap(8'h29);
    check_eq("t4_count3", 32'(queue_count), 3);
    sw_col = 3'd3;
    key_drop_n = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b1, 8'h29);
    check_eq("t4_count", 32'(queue_count), 4);
    check_eq("t4_ovf",   32'(overflow),    1);
    key_drop_n = 1'b1;
    step(1'b1, 8'hF0); step(1'b1, 8'h29);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_head", 32'({cmd_op, cmd_col}), 32'({2'b01, 3'd0}));
      step(1'b0, 8'h00);
    end
    check_eq("t4_empty", 32'(queue_count), 0);

    // full queue, enqueue with simultaneous dequeue
    cmd_ready = 1'b0;
    do_reset();
    repeat (3) tap(8'h29);
    tap(8'h2D);
    step(1'b1, 8'h36);
    check_eq("t5_full", 32'(queue_count), 4);
    check_eq("t5_cursor", 32'(cursor_col), 5);
    cmd_ready = 1'b1;
    step(1'b1, 8'h29);
    check_eq("t5_count", 32'(queue_count), 4);
    check_eq("t5_ovf",   32'(overflow),    0);
    cmd_ready = 1'b0;
    step(1'b1, 8'hF0); step(1'b1, 8'h29);
    heads = '{{2'b01, 3'd0}, {2'b01, 3'd0}, {2'b10, 3'd0}, {2'b01, 3'd5}};
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_head", 32'({cmd_op, cmd_col}), 32'(heads[i]));
      step(1'b0, 8'h00);
    end
    check_eq("t5_ovf_end", 32'(overflow), 0);

    // auto-repeat
    cmd_ready = 1'b0;
    do_reset();
    step(1'b1, 8'h29); step(1'b1, 8'h29); step(1'b1, 8'h29);
    step(1'b1, 8'hF0); step(1'b1, 8'h29);
    step(1'b1, 8'h29); step(1'b1, 8'h29);
`ifdef C4_TYPEMATIC_FILTER_EN
    check_eq("t6_repeat_count", 32'(queue_count), 2);
`else
    check_eq("t6_repeat_count", 32'(queue_count), 4);
`endif
    step(1'b1, 8'hF0); step(1'b1, 8'h29);

    // button: out-of-range column, then a good one
    do_reset();
    sw_col = 3'd7;
    key_drop_n = 1'b0;
    repeat (3) step(1'b0, 8'h00);
    check_eq("t7_bad_ovf",   32'(overflow),    1);
    check_eq("t7_bad_count", 32'(queue_count), 0);
    key_drop_n = 1'b1;
    do_reset();
    sw_col = 3'd2;
    key_drop_n = 1'b0;
    repeat (3) step(1'b0, 8'h00);
    check_eq("t7_btn_head", 32'({cmd_valid, cmd_op, cmd_col}), 32'({1'b1, 2'b01, 3'd2}));
    key_drop_n = 1'b1;

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      resetn    = ($urandom_range(0, 499) != 0);
      cmd_ready = ($urandom_range(0, 1) == 1);
      sw_col    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) key_drop_n = ~key_drop_n;
      step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)]);
    end
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
